// File: rtl/dht22_responder.sv
// DHT22 sensor-side responder: answers a host start pulse on the open-drain line with the
// presence response and a 40-bit humidity/temperature/checksum frame.
module dht22_responder #(
    parameter int unsigned TICKS_PER_US = 1,
    parameter int unsigned START_MIN_US = 1000,
    parameter int unsigned RESP_WAIT_US = 30,
    parameter int unsigned RESP_US      = 80,
    parameter int unsigned BIT_LOW_US   = 50,
    parameter int unsigned BIT0_HIGH_US = 26,
    parameter int unsigned BIT1_HIGH_US = 70,
    parameter int unsigned COOLDOWN_US  = 2000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    inout  wire         dht_pin_io,
    input  logic [15:0] humidity_i,
    input  logic [15:0] temperature_i,
    input  logic        corrupt_crc_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [7:0]  frame_count_o
);

    localparam logic [23:0] StartMin  = 24'(START_MIN_US * TICKS_PER_US);
    localparam logic [23:0] RespWait  = 24'(RESP_WAIT_US * TICKS_PER_US);
    localparam logic [23:0] RespLen   = 24'(RESP_US * TICKS_PER_US);
    localparam logic [23:0] BitLow    = 24'(BIT_LOW_US * TICKS_PER_US);
    localparam logic [23:0] Bit0High  = 24'(BIT0_HIGH_US * TICKS_PER_US);
    localparam logic [23:0] Bit1High  = 24'(BIT1_HIGH_US * TICKS_PER_US);
    localparam logic [23:0] Cooldown  = 24'(COOLDOWN_US * TICKS_PER_US);

    typedef enum logic [3:0] {
        StIdle,
        StHostLow,
        StRespWait,
        StRespL,
        StRespH,
        StBitL,
        StBitH,
        StEndL,
        StCooldown
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  sync_q;
    logic        line_q;
    logic [23:0] cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [39:0] frame_q, frame_d;
    logic        drive_low_q, drive_low_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_count_q, frame_count_d;

    logic        line_s, fall, rise;
    logic [7:0]  crc;
    logic [23:0] bit_high;

    assign dht_pin_io = drive_low_q ? 1'b0 : 1'bz;

    assign line_s = sync_q[1];
    assign fall   = line_q & ~line_s;
    assign rise   = ~line_q & line_s;

    // Phase of length len occupies counts 0 .. len-1 starting at the state-entry cycle.
    function automatic logic last_tick(input logic [23:0] cnt, input logic [23:0] len);
        return cnt == len - 24'd1;
    endfunction

    always_comb begin
        crc = humidity_i[15:8] + humidity_i[7:0] + temperature_i[15:8] + temperature_i[7:0];
        crc = crc ^ {8{corrupt_crc_i}};
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        bit_high      = frame_q[idx_q] ? Bit1High : Bit0High;

        case (state_q)
            StIdle: begin
                if (fall) state_d = StHostLow;
            end
            StHostLow: begin
                if (rise) begin
                    if (cnt_q >= StartMin) begin
                        frame_d = {humidity_i, temperature_i, crc};
                        state_d = StRespWait;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRespWait: begin
                if (last_tick(cnt_q, RespWait)) state_d = StRespL;
            end
            StRespL: begin
                if (last_tick(cnt_q, RespLen)) state_d = StRespH;
            end
            StRespH: begin
                if (last_tick(cnt_q, RespLen)) begin
                    idx_d   = 6'd39;
                    state_d = StBitL;
                end
            end
            StBitL: begin
                if (last_tick(cnt_q, BitLow)) state_d = StBitH;
            end
            StBitH: begin
                if (last_tick(cnt_q, bit_high)) begin
                    if (idx_q == 6'd0) begin
                        state_d = StEndL;
                    end else begin
                        idx_d   = idx_q - 6'd1;
                        state_d = StBitL;
                    end
                end
            end
            StEndL: begin
                if (last_tick(cnt_q, BitLow)) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = StCooldown;
                end
            end
            StCooldown: begin
                if (last_tick(cnt_q, Cooldown)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end

        drive_low_d = (state_d == StRespL) || (state_d == StBitL) || (state_d == StEndL);
        busy_d      = (state_d != StIdle) && (state_d != StHostLow);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            sync_q        <= 2'b11;
            line_q        <= 1'b1;
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_q       <= '0;
            drive_low_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= {sync_q[0], dht_pin_io};
            line_q        <= line_s;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            drive_low_q   <= drive_low_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_dht22_responder.sv
// Bench for dht22_responder: a host drives start pulses, the line waveform is decoded into
// run lengths and bits and compared with a frame model built from the sensor values.
module tb_dht22_responder;

    localparam int unsigned F_START = 4;
    localparam int unsigned F_WAIT  = 1;
    localparam int unsigned F_RESP  = 2;
    localparam int unsigned F_BLOW  = 1;
    localparam int unsigned F_B0    = 1;
    localparam int unsigned F_B1    = 2;
    localparam int unsigned F_COOL  = 6;
    localparam int RUN_LIMIT = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        host_low_m, host_low_f;
    logic [15:0] hum, temp;
    logic        corrupt;
    wire         line_m, line_f;
    logic        busy_m, busy_f, fd_m, fd_f;
    logic [7:0]  cnt_m, cnt_f;

    pullup (line_m);
    pullup (line_f);
    assign line_m = host_low_m ? 1'b0 : 1'bz;
    assign line_f = host_low_f ? 1'b0 : 1'bz;

    dht22_responder u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .dht_pin_io    (line_m),
        .humidity_i    (hum),
        .temperature_i (temp),
        .corrupt_crc_i (corrupt),
        .busy_o        (busy_m),
        .frame_done_o  (fd_m),
        .frame_count_o (cnt_m)
    );

    // Shrunken timing so that 256 back-to-back frames stay short.
    dht22_responder #(
        .TICKS_PER_US (1),
        .START_MIN_US (F_START),
        .RESP_WAIT_US (F_WAIT),
        .RESP_US      (F_RESP),
        .BIT_LOW_US   (F_BLOW),
        .BIT0_HIGH_US (F_B0),
        .BIT1_HIGH_US (F_B1),
        .COOLDOWN_US  (F_COOL)
    ) u_fast (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .dht_pin_io    (line_f),
        .humidity_i    (hum),
        .temperature_i (temp),
        .corrupt_crc_i (corrupt),
        .busy_o        (busy_f),
        .frame_done_o  (fd_f),
        .frame_count_o (cnt_f)
    );

    bit         sel_fast;
    wire        line_s = sel_fast ? line_f : line_m;
    wire        busy_s = sel_fast ? busy_f : busy_m;
    wire        fd_s   = sel_fast ? fd_f : fd_m;
    wire  [7:0] cnt_s  = sel_fast ? cnt_f : cnt_m;

    int w_start, w_wait, w_resp, w_blow, w_b0, w_b1, w_cool;
    int n_vec = 0;
    int n_bad = 0;
    int pulses_m = 0;
    int pulses_f = 0;
    int exp_pulses_m = 0;
    int exp_pulses_f = 0;
    logic [7:0] exp_cnt_m = '0;
    logic [7:0] exp_cnt_f = '0;

    always @(negedge clk) begin
        if (fd_m) pulses_m++;
        if (fd_f) pulses_f++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame as a DHT22 would send it: humidity, temperature, byte-sum checksum.
    function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t,
                                                input logic c);
        int sum;
        logic [7:0] crc;
        sum = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
        crc = 8'(sum % 256);
        if (c) crc = ~crc;
        return {h, t, crc};
    endfunction

    task automatic use_fast(input bit f);
        sel_fast = f;
        if (f) begin
            w_start = F_START + 2; w_wait = F_WAIT; w_resp = F_RESP; w_blow = F_BLOW;
            w_b0 = F_B0; w_b1 = F_B1; w_cool = F_COOL;
        end else begin
            w_start = 1100; w_wait = 30; w_resp = 80; w_blow = 50;
            w_b0 = 26; w_b1 = 70; w_cool = 2000;
        end
    endtask

    task automatic host_pulse(input int cycles);
        @(posedge clk);
        #1;
        if (sel_fast) host_low_f = 1'b1;
        else host_low_m = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        host_low_m = 1'b0;
        host_low_f = 1'b0;
    endtask

    // Current sample is taken to be the first of the run.
    task automatic run_len(input logic lvl, output int len);
        len = 1;
        while (len < RUN_LIMIT) begin
            @(negedge clk);
            if (line_s !== lvl) break;
            len++;
        end
    endtask

    task automatic watch_quiet(input int n, input bit chk_busy, input string tag);
        bit ok = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (line_s !== 1'b1) ok = 1'b0;
            if (chk_busy && busy_s !== 1'b0) ok = 1'b0;
        end
        check_eq(tag, ok, 1'b1);
    endtask

    // Released time after host release includes two synchronizer flops plus the state register.
    task automatic capture(input logic [39:0] exp, input bit timing, input int abort_at,
                           output logic [39:0] got);
        int len;
        got = '0;
        @(negedge clk);
        run_len(1'b1, len);
        if (timing) check_eq("resp_wait", len, w_wait + 3);
        hum     = 16'($urandom());
        temp    = 16'($urandom());
        corrupt = 1'($urandom());
        run_len(1'b0, len);
        if (timing) check_eq("resp_low", len, w_resp);
        run_len(1'b1, len);
        if (timing) check_eq("resp_high", len, w_resp);
        for (int i = 39; i >= 0; i--) begin
            if (i == abort_at) return;
            run_len(1'b0, len);
            if (timing) check_eq("bit_low", len, w_blow);
            run_len(1'b1, len);
            got[i] = (len >= w_b1);
            if (timing) check_eq($sformatf("bit%0d_high", i), len, exp[i] ? w_b1 : w_b0);
        end
        run_len(1'b0, len);
        check_eq("end_low", len, w_blow);
    endtask

    task automatic run_frame(input logic [15:0] h, input logic [15:0] t, input logic c,
                             input bit timing, input bit wait_cool);
        logic [39:0] exp, got;
        hum     = h;
        temp    = t;
        corrupt = c;
        exp     = model_frame(h, t, c);
        host_pulse(w_start);
        capture(exp, timing, -1, got);
        check_eq("frame", got, exp);
        check_eq("frame_done", fd_s, 1'b1);
        check_eq("busy_cooldown", busy_s, 1'b1);
        if (sel_fast) begin
            exp_cnt_f++;
            exp_pulses_f++;
        end else begin
            exp_cnt_m++;
            exp_pulses_m++;
        end
        check_eq("frame_count", cnt_s, sel_fast ? exp_cnt_f : exp_cnt_m);
        if (wait_cool) begin
            repeat (w_cool + 2) @(negedge clk);
            check_eq("busy_idle", busy_s, 1'b0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] exp, got;
        rst_n      = 1'b0;
        host_low_m = 1'b0;
        host_low_f = 1'b0;
        hum        = '0;
        temp       = '0;
        corrupt    = 1'b0;
        use_fast(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_line", line_m, 1'b1);
        check_eq("rst_busy", busy_m, 1'b0);
        check_eq("rst_frame_done", fd_m, 1'b0);
        check_eq("rst_count", cnt_m, 8'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Nominal frame, then a negative temperature.
        run_frame(16'h028C, 16'h0101, 1'b0, 1'b1, 1'b1);
        run_frame(16'h01F4, 16'h8065, 1'b0, 1'b1, 1'b1);

        // Short host pulse is ignored; a longer one then works.
        host_pulse(500);
        watch_quiet(200, 1'b1, "short_pulse_quiet");
        check_eq("short_pulse_count", cnt_m, exp_cnt_m);
        hum = 16'($urandom());
        run_frame(hum, 16'($urandom()), 1'b0, 1'b0, 1'b1);

        // Corrupted checksum: data bytes intact, crc inverted.
        run_frame(16'h028C, 16'h0101, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of bit 17.
        hum     = 16'($urandom());
        temp    = 16'($urandom());
        corrupt = 1'b0;
        exp     = model_frame(hum, temp, 1'b0);
        host_pulse(w_start);
        capture(exp, 1'b0, 17, got);
        repeat (10) @(negedge clk);
        check_eq("bit17_driven_low", line_m, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midframe_rst_line", line_m, 1'b1);
        check_eq("midframe_rst_count", cnt_m, 8'd0);
        check_eq("midframe_rst_busy", busy_m, 1'b0);
        exp_cnt_m = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        hum = 16'($urandom());
        run_frame(hum, 16'($urandom()), 1'b0, 1'b1, 1'b1);

        // A start issued during cooldown is ignored.
        hum = 16'($urandom());
        run_frame(hum, 16'($urandom()), 1'b0, 1'b0, 1'b0);
        host_pulse(w_start);
        watch_quiet(1500, 1'b0, "cooldown_start_ignored");
        check_eq("cooldown_busy_clear", busy_m, 1'b0);
        check_eq("cooldown_count", cnt_m, exp_cnt_m);

        // 256 back-to-back frames on the fast instance wrap the counter.
        use_fast(1'b1);
        for (int n = 0; n < 256; n++) begin
            hum = 16'($urandom());
            run_frame(hum, 16'($urandom()), 1'($urandom()), n == 0, 1'b1);
        end
        check_eq("wrap_count", cnt_f, 8'd0);

        repeat (4) @(negedge clk);
        check_eq("pulses_main", pulses_m, exp_pulses_m);
        check_eq("pulses_fast", pulses_f, exp_pulses_f);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dht22_responder.md
Name: dht22_responder

Overview:
Behavioural-synthesizable model of the DHT22 sensor side of the single-wire protocol: the device end answering the existing DHT22 host reader on the shared open-drain line. It detects the host start pulse, sends the 80/80 us presence response, then transmits a 40-bit frame (humidity, temperature, checksum). It is used on the board and in benches to close the loop on dht_pin without a physical sensor.

Parameters:
TICKS_PER_US, 1, clk cycles per microsecond; all timing below is in us × TICKS_PER_US.
START_MIN_US, 1000, minimum host-low width accepted as a start request.
RESP_WAIT_US, 30, released time after host release before the response begins.
RESP_US, 80, width of each response phase (low, then released).
BIT_LOW_US, 50, low lead-in of every bit and of the end pulse.
BIT0_HIGH_US, 26, released width encoding a 0.
BIT1_HIGH_US, 70, released width encoding a 1.
COOLDOWN_US, 2000, time after a frame during which starts are ignored.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
dht_pin  inout  1  open-drain data line: driven 0 or high-Z only; external pull-up
humidity  input  16  humidity ×10, unsigned
temperature  input  16  temperature ×10, bit15 = sign, bits14:0 = magnitude
corrupt_crc  input  1  test hook: when 1 at snapshot, transmitted checksum is inverted
busy  output  1  high from start acceptance until the end of COOLDOWN
frame_done  output  1  one-cycle pulse when the end pulse is released
frame_count  output  8  completed frames, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0: line released (high-Z), busy=0, frame_done=0, frame_count=0, state=IDLE, counters cleared. Reset mid-frame releases the line immediately; no partial frame resumes.
- Input sampling: dht_pin passes through a 2-flop synchronizer. All edge decisions use the synchronized value, so there are 2 cycles of latency.
- Drive: dht_pin = 0 when drive_low is set, else high-Z. drive_low is registered.
- Tick counter: 24-bit, saturating. It is reset on every state entry.
- IDLE: line released. On a synchronized falling edge, go to HOST_LOW.
- HOST_LOW: count while the line is low. On a rising edge:
  - if count >= START_MIN_US: snapshot humidity, temperature and corrupt_crc; set busy=1; go to RESP_WAIT.
  - otherwise go back to IDLE (glitch or short pulse is ignored).
  - A host low that never ends stays in HOST_LOW with a saturated count.
- RESP_WAIT: released for RESP_WAIT_US, then go to RESP_L.
- RESP_L: driven low for RESP_US, then go to RESP_H.
- RESP_H: released for RESP_US, then go to BIT_L with bit index 39.
- BIT_L: driven low for BIT_LOW_US, then go to BIT_H.
- BIT_H: released for BIT0_HIGH_US or BIT1_HIGH_US, chosen by frame[index]. Then:
  - if index = 0, go to END_L;
  - otherwise decrement index and go to BIT_L.
- Frame layout, MSB first: {hum[15:8], hum[7:0], temp[15:8], temp[7:0], crc}.
  - crc = (hum_hi + hum_lo + temp_hi + temp_lo) mod 256.
  - crc is computed from the snapshot and bitwise inverted when the corrupt_crc snapshot is 1.
- END_L: driven low for BIT_LOW_US. Then release the line, pulse frame_done, increment frame_count, go to COOLDOWN.
- COOLDOWN: released for COOLDOWN_US. Line activity is ignored. Then busy=0 and go to IDLE. A host low already in progress at IDLE entry is not treated as a start; a fresh falling edge is required.
- Line activity from RESP_WAIT through END_L is ignored; the responder does not detect contention.
- Input changes to humidity/temperature after the snapshot do not affect the frame in flight.
- Each phase lasts exactly N×TICKS_PER_US cycles, with no ±1 slop. Phases are measured from the state-entry cycle.

Test Plan:
1. TICKS_PER_US=1, hum=0x028C, temp=0x0101; host low 1100 us, then release -> released 30, low 80, high 80; then 40 bits giving 0x028C0101 followed by crc 0x90; frame_done pulses once; frame_count=1.
2. hum=0x01F4, temp=0x8065 (−10.1 C) -> temperature bits begin with 1; crc=0xDA; each 1-bit high phase is exactly 70 cycles, each 0-bit exactly 26.
3. Host low 500 us, then release -> no response; busy stays 0. A following 1200 us low produces a full frame.
4. corrupt_crc=1 at snapshot with the values of scenario 1 -> crc byte transmitted as 0x6F; the data bytes are unchanged.
5. Assert rst=0 during bit 17 -> line high-Z in the same cycle; frame_count=0; next valid start gives a complete correct frame.
6. Start during COOLDOWN -> ignored. Run 256 back-to-back valid frames -> frame_count wraps to 0.
